// File: rtl/d_axi_arb_pkg.sv
// Shared types and constants for the data-side N:1 AXI round-robin arbiter.
package d_axi_arb_pkg;

  localparam int AXI_LEN_W  = 8;
  localparam int AXI_SIZE_W = 3;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_ADDR,
    RD_DATA
  } rd_state_t;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_ADDR,
    WR_DATA,
    WR_RESP
  } wr_state_t;

  // Low bit of requestor idx's field inside a flattened per-requestor bus.
  function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: one-hot grant to the first requester at or
// after the pointer, wrapping modulo NUM_REQ.
module rr_picker #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o
);

  logic             found;
  logic [PTR_W-1:0] idx;

  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    idx     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = PTR_W'((int'(ptr_i) + k) % NUM_REQ);
      if (!found && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/d_axi_rr_arbiter.sv
// N-requestor to single AXI master arbiter; independent read and write FSMs,
// round-robin fairness, grant held for a whole burst.
module d_axi_rr_arbiter
  import d_axi_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ*ADDR_W-1:0]       s_araddr,
  input  logic [NUM_REQ*AXI_LEN_W-1:0]    s_arlen,
  input  logic [NUM_REQ*AXI_SIZE_W-1:0]   s_arsize,
  input  logic [NUM_REQ-1:0]              s_arvalid,
  output logic [NUM_REQ-1:0]              s_arready,
  output logic [DATA_W-1:0]               s_rdata,
  output logic                            s_rlast,
  output logic [NUM_REQ-1:0]              s_rvalid,
  input  logic [NUM_REQ-1:0]              s_rready,
  input  logic [NUM_REQ*ADDR_W-1:0]       s_awaddr,
  input  logic [NUM_REQ*AXI_LEN_W-1:0]    s_awlen,
  input  logic [NUM_REQ*AXI_SIZE_W-1:0]   s_awsize,
  input  logic [NUM_REQ-1:0]              s_awvalid,
  output logic [NUM_REQ-1:0]              s_awready,
  input  logic [NUM_REQ*DATA_W-1:0]       s_wdata,
  input  logic [NUM_REQ*(DATA_W/8)-1:0]   s_wstrb,
  input  logic [NUM_REQ-1:0]              s_wlast,
  input  logic [NUM_REQ-1:0]              s_wvalid,
  output logic [NUM_REQ-1:0]              s_wready,
  output logic [NUM_REQ-1:0]              s_bvalid,
  input  logic [NUM_REQ-1:0]              s_bready,
  output logic [ADDR_W-1:0]               m_araddr,
  output logic [AXI_LEN_W-1:0]            m_arlen,
  output logic [AXI_SIZE_W-1:0]           m_arsize,
  output logic                            m_arvalid,
  input  logic                            m_arready,
  input  logic [DATA_W-1:0]               m_rdata,
  input  logic                            m_rlast,
  input  logic                            m_rvalid,
  output logic                            m_rready,
  output logic [ADDR_W-1:0]               m_awaddr,
  output logic [AXI_LEN_W-1:0]            m_awlen,
  output logic [AXI_SIZE_W-1:0]           m_awsize,
  output logic                            m_awvalid,
  input  logic                            m_awready,
  output logic [DATA_W-1:0]               m_wdata,
  output logic [DATA_W/8-1:0]             m_wstrb,
  output logic                            m_wlast,
  output logic                            m_wvalid,
  input  logic                            m_wready,
  input  logic                            m_bvalid,
  output logic                            m_bready,
  output logic [NUM_REQ-1:0]              rd_grant,
  output logic [NUM_REQ-1:0]              wr_grant,
  output logic                            rd_len_err
);

  localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int STRB_W = DATA_W / 8;

  rd_state_t               rd_state_q, rd_state_d;
  wr_state_t               wr_state_q, wr_state_d;
  logic [NUM_REQ-1:0]      rd_grant_q, rd_grant_d, wr_grant_q, wr_grant_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AXI_LEN_W-1:0]    rd_left_q, rd_left_d;
  logic                    rd_len_err_q, rd_len_err_d;

  logic [NUM_REQ-1:0]      rd_pick, wr_pick;
  logic [PTR_W-1:0]        rd_ptr_adv, wr_ptr_adv;
  logic [AXI_LEN_W-1:0]    sel_arlen;
  logic                    sel_arvalid, sel_rready, sel_awvalid, sel_wvalid, sel_bready;
  logic                    rd_in_addr, rd_in_data, wr_in_addr, wr_in_data, wr_in_resp;
  logic                    rd_beat, wr_beat;

  rr_picker #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_rd_pick (
    .req_i   (s_arvalid),
    .ptr_i   (rd_ptr_q),
    .grant_o (rd_pick)
  );

  rr_picker #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_wr_pick (
    .req_i   (s_awvalid),
    .ptr_i   (wr_ptr_q),
    .grant_o (wr_pick)
  );

  // Owner mux: grants are one-hot and all-zero while idle, so idle drives zeros.
  always_comb begin
    m_araddr    = '0;
    m_arlen     = '0;
    m_arsize    = '0;
    sel_arlen   = '0;
    sel_arvalid = 1'b0;
    sel_rready  = 1'b0;
    rd_ptr_adv  = rd_ptr_q;
    m_awaddr    = '0;
    m_awlen     = '0;
    m_awsize    = '0;
    m_wdata     = '0;
    m_wstrb     = '0;
    m_wlast     = 1'b0;
    sel_awvalid = 1'b0;
    sel_wvalid  = 1'b0;
    sel_bready  = 1'b0;
    wr_ptr_adv  = wr_ptr_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rd_grant_q[i]) begin
        m_araddr    = s_araddr[slice_lo(i, ADDR_W) +: ADDR_W];
        m_arlen     = s_arlen[slice_lo(i, AXI_LEN_W) +: AXI_LEN_W];
        m_arsize    = s_arsize[slice_lo(i, AXI_SIZE_W) +: AXI_SIZE_W];
        sel_arlen   = s_arlen[slice_lo(i, AXI_LEN_W) +: AXI_LEN_W];
        sel_arvalid = s_arvalid[i];
        sel_rready  = s_rready[i];
        rd_ptr_adv  = PTR_W'((i + 1) % NUM_REQ);
      end
      if (wr_grant_q[i]) begin
        m_awaddr    = s_awaddr[slice_lo(i, ADDR_W) +: ADDR_W];
        m_awlen     = s_awlen[slice_lo(i, AXI_LEN_W) +: AXI_LEN_W];
        m_awsize    = s_awsize[slice_lo(i, AXI_SIZE_W) +: AXI_SIZE_W];
        m_wdata     = s_wdata[slice_lo(i, DATA_W) +: DATA_W];
        m_wstrb     = s_wstrb[slice_lo(i, STRB_W) +: STRB_W];
        m_wlast     = s_wlast[i];
        sel_awvalid = s_awvalid[i];
        sel_wvalid  = s_wvalid[i];
        sel_bready  = s_bready[i];
        wr_ptr_adv  = PTR_W'((i + 1) % NUM_REQ);
      end
    end
  end

  assign rd_in_addr = (rd_state_q == RD_ADDR);
  assign rd_in_data = (rd_state_q == RD_DATA);
  assign wr_in_addr = (wr_state_q == WR_ADDR);
  assign wr_in_data = (wr_state_q == WR_DATA);
  assign wr_in_resp = (wr_state_q == WR_RESP);

  assign m_arvalid = rd_in_addr & sel_arvalid;
  assign s_arready = rd_grant_q & {NUM_REQ{rd_in_addr & m_arready}};
  assign m_rready  = rd_in_data & sel_rready;
  assign s_rvalid  = rd_grant_q & {NUM_REQ{rd_in_data & m_rvalid}};
  assign s_rdata   = m_rdata;
  assign s_rlast   = m_rlast;
  assign rd_beat   = rd_in_data & m_rvalid & m_rready;

  assign m_awvalid = wr_in_addr & sel_awvalid;
  assign s_awready = wr_grant_q & {NUM_REQ{wr_in_addr & m_awready}};
  assign m_wvalid  = wr_in_data & sel_wvalid;
  assign s_wready  = wr_grant_q & {NUM_REQ{wr_in_data & m_wready}};
  assign m_bready  = wr_in_resp & sel_bready;
  assign s_bvalid  = wr_grant_q & {NUM_REQ{wr_in_resp & m_bvalid}};
  assign wr_beat   = wr_in_data & m_wvalid & m_wready;

  assign rd_grant   = rd_grant_q;
  assign wr_grant   = wr_grant_q;
  assign rd_len_err = rd_len_err_q;

  always_comb begin
    rd_state_d   = rd_state_q;
    rd_grant_d   = rd_grant_q;
    rd_ptr_d     = rd_ptr_q;
    rd_left_d    = rd_left_q;
    rd_len_err_d = rd_len_err_q;
    unique case (rd_state_q)
      RD_IDLE: begin
        if (|s_arvalid) begin
          rd_grant_d = rd_pick;
          rd_state_d = RD_ADDR;
        end
      end
      RD_ADDR: begin
        if (m_arvalid && m_arready) begin
          rd_left_d  = sel_arlen;
          rd_state_d = RD_DATA;
        end
      end
      RD_DATA: begin
        if (rd_beat) begin
          if (m_rlast) begin
            if (rd_left_q != '0) rd_len_err_d = 1'b1;
            rd_state_d = RD_IDLE;
            rd_grant_d = '0;
            rd_ptr_d   = rd_ptr_adv;
          end else if (rd_left_q == '0) begin
            rd_len_err_d = 1'b1;
          end else begin
            rd_left_d = rd_left_q - 8'd1;
          end
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  always_comb begin
    wr_state_d = wr_state_q;
    wr_grant_d = wr_grant_q;
    wr_ptr_d   = wr_ptr_q;
    unique case (wr_state_q)
      WR_IDLE: begin
        if (|s_awvalid) begin
          wr_grant_d = wr_pick;
          wr_state_d = WR_ADDR;
        end
      end
      WR_ADDR: if (m_awvalid && m_awready) wr_state_d = WR_DATA;
      WR_DATA: if (wr_beat && m_wlast) wr_state_d = WR_RESP;
      WR_RESP: begin
        if (m_bvalid && m_bready) begin
          wr_state_d = WR_IDLE;
          wr_grant_d = '0;
          wr_ptr_d   = wr_ptr_adv;
        end
      end
      default: wr_state_d = WR_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_state_q   <= RD_IDLE;
      rd_grant_q   <= '0;
      rd_ptr_q     <= '0;
      rd_left_q    <= '0;
      rd_len_err_q <= 1'b0;
      wr_state_q   <= WR_IDLE;
      wr_grant_q   <= '0;
      wr_ptr_q     <= '0;
    end else begin
      rd_state_q   <= rd_state_d;
      rd_grant_q   <= rd_grant_d;
      rd_ptr_q     <= rd_ptr_d;
      rd_left_q    <= rd_left_d;
      rd_len_err_q <= rd_len_err_d;
      wr_state_q   <= wr_state_d;
      wr_grant_q   <= wr_grant_d;
      wr_ptr_q     <= wr_ptr_d;
    end
  end

endmodule

// File: tb/tb_d_axi_rr_arbiter.sv
// Directed bench for d_axi_rr_arbiter with NUM_REQ=2; inputs change and outputs
// are sampled 1-2 ns after the rising edge.
module tb_d_axi_rr_arbiter;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [N*AW-1:0]     s_araddr, s_awaddr;
  logic [N*8-1:0]      s_arlen, s_awlen;
  logic [N*3-1:0]      s_arsize, s_awsize;
  logic [N-1:0]        s_arvalid, s_arready, s_rvalid, s_rready;
  logic [N-1:0]        s_awvalid, s_awready, s_wvalid, s_wready, s_wlast;
  logic [N-1:0]        s_bvalid, s_bready, rd_grant, wr_grant;
  logic [DW-1:0]       s_rdata;
  logic                s_rlast;
  logic [N*DW-1:0]     s_wdata;
  logic [N*DW/8-1:0]   s_wstrb;
  logic [AW-1:0]       m_araddr, m_awaddr;
  logic [7:0]          m_arlen, m_awlen;
  logic [2:0]          m_arsize, m_awsize;
  logic                m_arvalid, m_arready, m_rvalid, m_rready, m_rlast;
  logic                m_awvalid, m_awready, m_wvalid, m_wready, m_wlast;
  logic                m_bvalid, m_bready, rd_len_err;
  logic [DW-1:0]       m_rdata, m_wdata;
  logic [DW/8-1:0]     m_wstrb;
  logic [1:0]          exp_g;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  d_axi_rr_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rlast(s_rlast), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
    .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bvalid(s_bvalid), .s_bready(s_bready),
    .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
    .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bvalid(m_bvalid), .m_bready(m_bready),
    .rd_grant(rd_grant), .wr_grant(wr_grant), .rd_len_err(rd_len_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    s_araddr = {32'h1000_0040, 32'h0000_0100};
    s_arlen  = {8'd3, 8'd0};
    s_arsize = {3'd2, 3'd2};
    s_awaddr = {32'h3000_0000, 32'h2000_0000};
    s_awlen  = {8'd0, 8'd1};
    s_awsize = {3'd2, 3'd2};
    s_wdata  = {32'hDEAD_BEEF, 32'h1111_1111};
    s_wstrb  = {4'hF, 4'h3};
    s_wlast = '0; s_arvalid = '0; s_rready = '0; s_awvalid = '0; s_wvalid = '0; s_bready = '0;
    m_arready = 0; m_rdata = '0; m_rlast = 0; m_rvalid = 0;
    m_awready = 0; m_wready = 0; m_bvalid = 0;

    // reset state
    repeat (3) step();
    chk("rst_grants", 64'({rd_grant, wr_grant}), 64'h0);
    chk("rst_valids", 64'({m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready, s_arready, s_awready}), 64'h0);
    chk("rst_len_err", 64'(rd_len_err), 64'h0);
    rst = 0;
    step();

    // req1 alone reads 4 beats
    s_arvalid = 2'b10;
    #1 chk("a_no_early_arvalid", 64'(m_arvalid), 64'h0);
    step();
    chk("a_grant", 64'(rd_grant), 64'h2);
    chk("a_arvalid", 64'(m_arvalid), 64'h1);
    chk("a_araddr", 64'(m_araddr), 64'h1000_0040);
    chk("a_arlen", 64'(m_arlen), 64'h3);
    m_arready = 1;
    #1 chk("a_arready", 64'(s_arready), 64'h2);
    step();
    s_arvalid = 2'b00; m_arready = 0; s_rready = 2'b10; m_rvalid = 1;
    for (int b = 0; b < 4; b++) begin
      m_rdata = 32'hA0 + b;
      m_rlast = (b == 3);
      #1 chk("a_rvalid", 64'(s_rvalid), 64'h2);
      chk("a_rdata", 64'(s_rdata), 64'(32'hA0 + b));
      step();
    end
    m_rvalid = 0; m_rlast = 0; s_rready = '0;
    #1 chk("a_release", 64'({rd_grant, rd_len_err}), 64'h0);

    // both request single-beat bursts continuously; grants alternate
    s_arlen = {8'd0, 8'd0};
    s_arvalid = 2'b11; m_arready = 1; m_rvalid = 1; m_rlast = 1; s_rready = 2'b11;
    exp_g = 2'b01;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("b_alternate", 64'(rd_grant), 64'(exp_g));
      exp_g = {exp_g[0], exp_g[1]};
      step();
      step();
    end
    s_arvalid = '0; m_arready = 0; m_rvalid = 0; m_rlast = 0; s_rready = '0;

    // req0 write, B held off 5 cycles while req1 waits
    s_awvalid = 2'b01;
    step();
    s_awvalid = 2'b11;
    #1 chk("c_wgrant", 64'(wr_grant), 64'h1);
    chk("c_awaddr", 64'(m_awaddr), 64'h2000_0000);
    m_awready = 1;
    #1 chk("c_awready", 64'(s_awready), 64'h1);
    step();
    s_awvalid = 2'b10; m_awready = 0; s_wvalid = 2'b01; m_wready = 1;
    #1 chk("c_w0", 64'({m_wvalid, m_wstrb, s_wready}), 64'({1'b1, 4'b0011, 2'b01}));
    chk("c_wdata0", 64'(m_wdata), 64'h1111_1111);
    step();
    s_wdata[31:0] = 32'h2222_2222; s_wlast = 2'b01;
    #1 chk("c_w1", 64'({m_wlast, m_wdata}), 64'({1'b1, 32'h2222_2222}));
    step();
    s_wvalid = '0; s_wlast = '0; m_wready = 0; m_bvalid = 1; s_bready = 2'b00;
    repeat (5) begin
      #1 chk("c_resp_hold", 64'({wr_grant, s_bvalid, m_bready, m_awvalid}), 64'h14);
      step();
    end
    s_bready = 2'b01;
    #1 chk("c_bready", 64'(m_bready), 64'h1);
    step();
    m_bvalid = 0; s_bready = '0;
    #1 chk("c_idle_gap", 64'(wr_grant), 64'h0);
    step();
    chk("c_req1_wins", 64'({wr_grant, m_awaddr}), 64'({2'b10, 32'h3000_0000}));
    m_awready = 1;
    step();
    s_awvalid = '0; m_awready = 0; s_wvalid = 2'b10; s_wlast = 2'b10; m_wready = 1;
    #1 chk("c_req1_wdata", 64'(m_wdata), 64'hDEAD_BEEF);
    step();
    s_wvalid = '0; s_wlast = '0; m_wready = 0; m_bvalid = 1; s_bready = 2'b10;
    step();
    m_bvalid = 0; s_bready = '0;

    // concurrent read by req0 and write by req1
    s_arvalid = 2'b01; s_awvalid = 2'b10;
    step();
    chk("d_addr_both", 64'({rd_grant, wr_grant, m_arvalid, m_awvalid}), 64'h1B);
    m_arready = 1; m_awready = 1;
    step();
    s_arvalid = '0; s_awvalid = '0; m_arready = 0; m_awready = 0;
    m_rvalid = 1; m_rlast = 1; s_rready = 2'b01;
    s_wvalid = 2'b10; s_wlast = 2'b10; m_wready = 1;
    #1 chk("d_data_both", 64'({s_rvalid, s_wready, m_rready, m_wvalid}), 64'h1B);
    step();
    m_rvalid = 0; m_rlast = 0; s_rready = '0;
    s_wvalid = '0; s_wlast = '0; m_wready = 0; m_bvalid = 1; s_bready = 2'b10;
    step();
    m_bvalid = 0; s_bready = '0;

    // early rlast on beat 2 of arlen=3
    s_arlen = {8'd0, 8'd3};
    s_arvalid = 2'b01;
    step();
    m_arready = 1;
    step();
    s_arvalid = '0; m_arready = 0; m_rvalid = 1; s_rready = 2'b01; m_rlast = 0;
    #1 chk("e_no_err_yet", 64'(rd_len_err), 64'h0);
    step();
    m_rlast = 1;
    step();
    m_rvalid = 0; m_rlast = 0; s_rready = '0;
    #1 chk("e_len_err", 64'(rd_len_err), 64'h1);
    repeat (3) step();
    chk("e_len_err_sticky", 64'({rd_len_err, rd_grant}), 64'h4);

    // reset mid-burst, then a 256-beat burst by req0
    s_arlen = {8'd3, 8'd255};
    s_arvalid = 2'b10;
    step();
    m_arready = 1;
    step();
    s_arvalid = '0; m_arready = 0; m_rvalid = 1; s_rready = 2'b10;
    #1 chk("f_beat1", 64'(s_rvalid), 64'h2);
    rst = 1;
    #1 chk("f_rst_outputs", 64'({rd_grant, wr_grant, s_rvalid, m_rready, m_arvalid, rd_len_err}), 64'h0);
    step();
    rst = 0; m_rvalid = 0; s_rready = '0; s_arvalid = 2'b11;
    step();
    chk("f_req0_first", 64'(rd_grant), 64'h1);
    m_arready = 1;
    step();
    s_arvalid = '0; m_arready = 0; m_rvalid = 1; s_rready = 2'b01;
    for (int b = 0; b < 256; b++) begin
      m_rlast = (b == 255);
      step();
    end
    m_rvalid = 0; m_rlast = 0; s_rready = '0;
    #1 chk("f_256_beats", 64'({rd_len_err, rd_grant}), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/d_axi_rr_arbiter.md
# d_axi_rr_arbiter

Parametrised N-requestor to single-AXI-master arbiter for the data side of the memory subsystem. It generalises the two-path cached/uncached data arbiter. Any number of burst-capable requestors (D-cache, uncached config path, future write buffer or DMA) share one AXI master port. Read and write channels are arbitrated independently with round-robin fairness, and grants are held for a whole burst. The block sits between the data-side requestors and the top-level AXI crossbar.

## Interface
Parameters:
- NUM_REQ, 2: number of requestors; index 0 has the highest priority after reset.
- ADDR_W, 32: address width.
- DATA_W, 32: data width; power of two, at least 32.

Ports (per-requestor buses are flattened, requestor i occupies slice i):
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- s_araddr/s_arlen/s_arsize  in  NUM_REQ×{ADDR_W,8,3}  read address per requestor.
- s_arvalid  in  NUM_REQ; s_arready  out  NUM_REQ.
- s_rdata  out  DATA_W  broadcast; s_rlast  out  1  broadcast.
- s_rvalid  out  NUM_REQ; s_rready  in  NUM_REQ.
- s_awaddr/s_awlen/s_awsize  in  NUM_REQ×{ADDR_W,8,3}.
- s_awvalid  in  NUM_REQ; s_awready  out  NUM_REQ.
- s_wdata/s_wstrb/s_wlast  in  NUM_REQ×{DATA_W,DATA_W/8,1}.
- s_wvalid  in  NUM_REQ; s_wready  out  NUM_REQ.
- s_bvalid  out  NUM_REQ; s_bready  in  NUM_REQ.
- m_ar*/m_r*/m_aw*/m_w*/m_b*: the single AXI master port, same widths as one requestor slice.
- rd_grant, wr_grant  out  NUM_REQ  one-hot current owner; all-zero when idle.
- rd_len_err  out  1  sticky flag: the read beat count disagreed with arlen+1.

## Operation
- Read FSM states: RD_IDLE, RD_ADDR, RD_DATA.
  - RD_IDLE: when any s_arvalid is high, the rr_picker selects the first requestor at or after rd_ptr. The grant is registered and the FSM moves to RD_ADDR.
  - RD_ADDR: m_ar* = slice of the granted requestor; m_arvalid = its s_arvalid; its s_arready = m_arready. On handshake: latch arlen into rd_left, go to RD_DATA.
  - RD_DATA: m_rdata and m_rlast are broadcast. Only the granted requestor sees s_rvalid = m_rvalid. m_rready = s_rready of the grantee. rd_left decrements on each beat.
  - Release: a beat with rlast goes to RD_IDLE, clears rd_grant, and sets rd_ptr = owner+1 mod NUM_REQ.
  - rd_len_err is set if rlast arrives with rd_left≠0, or if a beat is seen with rd_left=0 and no rlast.
- Write FSM states: WR_IDLE, WR_ADDR, WR_DATA, WR_RESP. Same picking scheme on s_awvalid with wr_ptr.
  - The AW handshake moves WR_ADDR to WR_DATA.
  - The W channel is forwarded only in WR_DATA. A handshake with wlast moves to WR_RESP.
  - A B handshake (m_bvalid & grantee's s_bready) moves to WR_IDLE and advances wr_ptr.
- Non-granted requestors always see ready=0 and valid=0.
- The read and write FSMs are fully independent. Concurrent read and write to the same address carry no ordering guarantee; requestors order their own traffic.

## Timing
- Reset: both FSMs idle; rd_ptr = wr_ptr = 0; all m_*valid, m_*ready, s_*ready, s_*valid, grants and rd_len_err = 0.
- Arbitration latency: 1 cycle. If arvalid is seen in cycle t, m_arvalid is asserted in t+1, and the earliest accept is t+1.
- A requestor must hold valid until ready (AXI rule). A request that is withdrawn before grant is simply not selected.
- Back-to-back bursts: a new pick happens in the IDLE cycle after release, so there is a minimum 1 idle cycle between owners.
- A single requestor can re-win immediately if it is the only one requesting.
- Simultaneous requests are resolved by the pointer only; fairness means any waiting requestor is granted within NUM_REQ bursts.
- Reset asserted mid-burst: the FSMs return to idle immediately and the outstanding AXI transaction is abandoned. The downstream interconnect shares rst.
- rd_left is 8 bits. A 256-beat burst (arlen=255) counts down to 0 without wrap.

## Structure
- Package d_axi_arb_pkg holds:
  - rd_state_t and wr_state_t enums;
  - AXI_LEN_W=8 and AXI_SIZE_W=3;
  - a helper function for slice extraction.
- Sub-module rr_picker (NUM_REQ-wide, request vector plus pointer in, one-hot grant out) is purely combinational. It is instantiated twice, once for read and once for write.

## Test plan
- NUM_REQ=2, only req1 reads with arlen=3 → one cycle later m_araddr = req1 address; 4 beats reach only req1; rd_grant returns to 0 after rlast.
- req0 and req1 both assert arvalid every cycle for 6 single-beat bursts → grants alternate 0,1,0,1,0,1.
- req0 writes with awlen=1 and wstrb 4'b0011, then holds bready low 5 cycles → wr_grant held through WR_RESP; a req1 write waits until req0's B handshake.
- Concurrent read by req0 and write by req1 → both master channels active in the same cycle; no cross-blocking.
- Slave drives rlast on beat 2 of arlen=3 → rd_len_err=1 and stays 1 until reset.
- rst pulsed in RD_DATA beat 1 → the same cycle, all valids and grants are 0; after release, a new request is granted to req0 first.
